multicycle_ctrl: RTL

Sequencing controller that turns the existing single-cycle RV32 datapath (PC, instruction memory, register file, ALU) into a multi-cycle machine. It issues instruction-memory requests over a req/ack handshake that tolerates variable latency, latches control from the opcode, and pulses the PC/IR/register-file write enables once per instruction. It sits beside the datapath and replaces the combinational Control decoder plus the free-running PC update.

---
 rtl/mc_pkg.sv | 32 +++
 rtl/op_decode.sv | 44 ++++
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared types and constants for the multi-cycle RV32 sequencer:
//            FSM state encoding, supported opcodes, ALUOp codes and error
//            codes reported on err_code_o.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;

    localparam logic [1:0] ALUOP_R = 2'b10;
    localparam logic [1:0] ALUOP_I = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_ILLEGAL = 2'd2;

endpackage : mc_pkg
`default_nettype wire

// File: rtl/op_decode.sv
`default_nettype none
// ============================================================================
// Module   : op_decode
// Purpose  : Combinational opcode classifier. Maps a 7-bit RV32 opcode to a
//            legality flag plus the ALU operand select and ALUOp code.
//            Kept standalone so the pipelined core can reuse it.
// Ports    : op_i      - opcode, instr[6:0]
//            legal_o   - opcode is one this core executes
//            alu_src_o - 0 = rs2, 1 = sign-extended immediate
//            alu_op_o  - ALUOp for ALU_Control (0 when illegal)
// Revision : 1.0 - initial release
// ============================================================================
module op_decode
    import mc_pkg::*;
(
    input  logic [6:0] op_i,
    output logic       legal_o,
    output logic       alu_src_o,
    output logic [1:0] alu_op_o
);

    always_comb begin
        legal_o   = 1'b0;
        alu_src_o = 1'b0;
        alu_op_o  = 2'b00;
        case (op_i)
            OP_RTYPE: begin
                legal_o   = 1'b1;
                alu_src_o = 1'b0;
                alu_op_o  = ALUOP_R;
            end
            OP_ITYPE: begin
                legal_o   = 1'b1;
                alu_src_o = 1'b1;
                alu_op_o  = ALUOP_I;
            end
            default: begin
                legal_o   = 1'b0;
            end
        endcase
    end

endmodule : op_decode
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Sequencing controller turning the single-cycle RV32 datapath
//            into a multi-cycle machine: IDLE -> FETCH -> DECODE -> EXEC -> WB.
//            Fetch uses a req/ack handshake with a bounded wait; unsupported
//            opcodes and fetch timeouts park the FSM in a sticky ERROR state.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - synchronous reset, active low
//            start_i      - run enable, sampled in IDLE and WB only
//            op_i         - opcode from the IR
//            imem_req_o   - fetch request, held through FETCH
//            imem_ack_i   - fetch data valid (ignored outside FETCH)
//            ir_we_o      - IR load, in the ack cycle
//            pc_we_o      - PC <= PC+4, one pulse per instruction (WB)
//            reg_write_o  - register-file write, one pulse per instruction
//            alu_src_o    - operand select latched in DECODE
//            alu_op_o     - ALUOp latched in DECODE
//            busy_o       - running (not IDLE, not ERROR)
//            err_o        - sticky error flag
//            err_code_o   - 0 none, 1 fetch timeout, 2 illegal opcode
//            retired_o    - retired-instruction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [6:0]       op_i,
    output logic             imem_req_o,
    input  logic             imem_ack_i,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             reg_write_o,
    output logic             alu_src_o,
    output logic [1:0]       alu_op_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [CNT_W-1:0] retired_o
);

    // Wide enough to hold TIMEOUT itself, so the counter never wraps before
    // the FSM leaves FETCH.
    localparam int                  c_WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_alu_src;
    logic [1:0]          r_alu_op;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic [CNT_W-1:0]    r_retired;

    logic                w_imem_req;
    logic                w_ir_we;
    logic                w_wb;
    logic                w_set_err;
    logic [1:0]          w_err_code_nxt;

    logic                w_dec_legal;
    logic                w_dec_alu_src;
    logic [1:0]          w_dec_alu_op;

    op_decode u_op_decode (
        .op_i      (op_i),
        .legal_o   (w_dec_legal),
        .alu_src_o (w_dec_alu_src),
        .alu_op_o  (w_dec_alu_op)
    );

    // Next-state and strobe decode. Strobes depend only on the current state,
    // except ir_we which also qualifies on the ack in the same FETCH cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_imem_req     = 1'b0;
        w_ir_we        = 1'b0;
        w_wb           = 1'b0;
        w_set_err      = 1'b0;
        w_err_code_nxt = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_imem_req = 1'b1;
                // An ack in the last allowed cycle takes priority over timeout.
                if (imem_ack_i) begin
                    w_ir_we     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_state_nxt    = ST_ERROR;
                    w_set_err      = 1'b1;
                    w_err_code_nxt = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (w_dec_legal) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt    = ST_ERROR;
                    w_set_err      = 1'b1;
                    w_err_code_nxt = ERR_ILLEGAL;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_wb        = 1'b1;
                w_state_nxt = start_i ? ST_FETCH : ST_IDLE;
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_alu_src  <= 1'b0;
            r_alu_op   <= 2'b00;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_retired  <= '0;
        end else begin
            r_state <= w_state_nxt;

            // Held at zero outside FETCH, so every FETCH entry starts from 0.
            if ((r_state == ST_FETCH) && !imem_ack_i) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            if ((r_state == ST_DECODE) && w_dec_legal) begin
                r_alu_src <= w_dec_alu_src;
                r_alu_op  <= w_dec_alu_op;
            end

            if (w_set_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code_nxt;
            end

            if (w_wb) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign imem_req_o  = w_imem_req;
    assign ir_we_o     = w_ir_we;
    assign pc_we_o     = w_wb;
    assign reg_write_o = w_wb;
    assign alu_src_o   = r_alu_src;
    assign alu_op_o    = r_alu_op;
    assign busy_o      = (r_state != ST_IDLE) && (r_state != ST_ERROR);
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;
    assign retired_o   = r_retired;

endmodule : multicycle_ctrl
`default_nettype wire
